instr_fetch_unit: RTL and testbench

Instruction fetch stage that feeds the decode/control stage of the RV32I core. It holds the program counter and issues one word request at a time to instruction memory over a req/ack handshake. Returned words are buffered with their PC in a small FIFO. A taken branch (pcsrc plus target from the decode stage) flushes the buffer and redirects fetch.

---
 rtl/instr_fetch_unit.sv | 147 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word request at a time over
// req/ack, and buffers returned words with their PC for the decode stage.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int          PW  = $clog2(DEPTH);
    localparam int          CW  = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_DROP
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     req_addr_q, req_addr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]     buf_pc_q    [DEPTH];
    logic [31:0]     buf_instr_q [DEPTH];

    logic        push;
    logic        pop;
    logic [31:0] target_aligned;

    assign target_aligned = redirect_target & ~32'h3;

    // NOTE: every signal driven here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        push       = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (redirect) begin
                    fetch_pc_d = target_aligned;
                end else if (count_q < CW'(DEPTH)) begin
                    req_addr_d = fetch_pc_q;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    state_d = S_FETCH;
                    if (redirect) begin
                        fetch_pc_d = target_aligned;
                    end else begin
                        push       = 1'b1;
                        fetch_pc_d = req_addr_q + 32'd4;
                    end
                end else if (redirect) begin
                    fetch_pc_d = target_aligned;
                    state_d    = S_DROP;
                end
            end
            S_DROP: begin
                // The outstanding word belongs to the abandoned path; only the
                // latest redirect target matters.
                if (redirect) begin
                    fetch_pc_d = target_aligned;
                end
                if (imem_ack) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign pop = instr_valid && instr_ready && !redirect;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // NOTE: buffer storage is not reset; count_q alone decides whether an entry
    // is meaningful, so clearing the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc_q[wr_ptr_q]    <= req_addr_q;
            buf_instr_q[wr_ptr_q] <= imem_rdata;
        end
    end

    assign imem_req    = (state_q == S_WAIT) || (state_q == S_DROP);
    assign imem_addr   = req_addr_q;
    assign instr_valid = (count_q != '0);
    assign instr       = instr_valid ? buf_instr_q[rd_ptr_q] : NOP;
    assign instr_pc    = instr_valid ? buf_pc_q[rd_ptr_q]    : 32'h0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, hand-written corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    // Reference model: a request is either absent or outstanding, possibly
    // marked for discard; the buffer is a plain queue of {pc, word}.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    entry_t      m_q[$];
    bit          m_out;
    bit          m_discard;
    logic [31:0] m_fetch_pc;
    logic [31:0] m_req_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_edge();
        bit          pop;
        bit          push;
        entry_t      e;
        logic [31:0] nt;
        if (!rst_n) begin
            m_out      = 0;
            m_discard  = 0;
            m_fetch_pc = RESET_PC;
            m_req_addr = 32'h0;
            m_q.delete();
            return;
        end
        pop  = (m_q.size() != 0) && instr_ready && !redirect;
        push = 0;
        nt   = redirect_target & ~32'h3;
        e.pc   = 32'h0;
        e.word = 32'h0;
        if (m_out) begin
            if (imem_ack) begin
                m_out = 0;
                if (!m_discard && !redirect) begin
                    push       = 1;
                    e.pc       = m_req_addr;
                    e.word     = imem_rdata;
                    m_fetch_pc = m_req_addr + 32'd4;
                end
                m_discard = 0;
            end else if (redirect) begin
                m_discard = 1;
            end
            if (redirect) m_fetch_pc = nt;
        end else if (redirect) begin
            m_fetch_pc = nt;
        end else if (m_q.size() < DEPTH) begin
            m_req_addr = m_fetch_pc;
            m_out      = 1;
        end
        if (redirect) begin
            m_q.delete();
        end else begin
            if (pop)  m_q.delete(0);
            if (push) m_q.push_back(e);
        end
    endtask

    task automatic compare_model();
        check("rnd_req",   {31'h0, imem_req},    {31'h0, m_out});
        check("rnd_addr",  imem_addr,            m_req_addr);
        check("rnd_valid", {31'h0, instr_valid}, {31'h0, m_q.size() != 0});
        check("rnd_instr", instr,    (m_q.size() != 0) ? m_q[0].word : NOP);
        check("rnd_pc",    instr_pc, (m_q.size() != 0) ? m_q[0].pc   : 32'h0);
    endtask

    // Drive one cycle of inputs, let the edge happen, then sample 1 time unit later.
    task automatic apply(input logic r, input logic a, input logic [31:0] d,
                         input logic rd, input logic [31:0] t, input logic rdy);
        rst_n           = r;
        imem_ack        = a;
        imem_rdata      = d;
        redirect        = rd;
        redirect_target = t;
        instr_ready     = rdy;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        logic        rst_n;
        logic        ack;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic a, input logic [31:0] d, input logic rdy,
                                input logic eq, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ei, input logic [31:0] ep);
        vec_t v;
        v.rst_n = r;  v.ack = a;  v.rdata = d;  v.rdy = rdy;
        v.e_req = eq; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_pc = ep;
        return v;
    endfunction

    vec_t vecs[12];

    initial begin
        // Reset, 1-cycle acks with ready high, then ready low to fill the buffer.
        vecs[0]  = mk(0, 0, 32'h0,         1, 0, 32'd0,  0, NOP,           32'd0);
        vecs[1]  = mk(1, 0, 32'h0,         1, 1, 32'd0,  0, NOP,           32'd0);
        vecs[2]  = mk(1, 1, 32'hA000_0000, 1, 0, 32'd0,  1, 32'hA000_0000, 32'd0);
        vecs[3]  = mk(1, 0, 32'h0,         1, 1, 32'd4,  0, NOP,           32'd0);
        vecs[4]  = mk(1, 1, 32'hA000_0001, 1, 0, 32'd4,  1, 32'hA000_0001, 32'd4);
        vecs[5]  = mk(1, 0, 32'h0,         1, 1, 32'd8,  0, NOP,           32'd0);
        vecs[6]  = mk(1, 1, 32'hA000_0002, 1, 0, 32'd8,  1, 32'hA000_0002, 32'd8);
        vecs[7]  = mk(1, 0, 32'h0,         0, 1, 32'd12, 1, 32'hA000_0002, 32'd8);
        vecs[8]  = mk(1, 1, 32'hA000_0003, 0, 0, 32'd12, 1, 32'hA000_0002, 32'd8);
        vecs[9]  = mk(1, 0, 32'h0,         0, 0, 32'd12, 1, 32'hA000_0002, 32'd8);
        vecs[10] = mk(1, 0, 32'h0,         1, 0, 32'd12, 1, 32'hA000_0003, 32'd12);
        vecs[11] = mk(1, 0, 32'h0,         0, 1, 32'd16, 1, 32'hA000_0003, 32'd12);

        for (int i = 0; i < 12; i++) begin
            apply(vecs[i].rst_n, vecs[i].ack, vecs[i].rdata, 1'b0, 32'h0, vecs[i].rdy);
            check($sformatf("vec%0d_req", i),   {31'h0, imem_req},    {31'h0, vecs[i].e_req});
            check($sformatf("vec%0d_addr", i),  imem_addr,            vecs[i].e_addr);
            check($sformatf("vec%0d_valid", i), {31'h0, instr_valid}, {31'h0, vecs[i].e_valid});
            check($sformatf("vec%0d_instr", i), instr,                vecs[i].e_instr);
            check($sformatf("vec%0d_pc", i),    instr_pc,             vecs[i].e_pc);
        end

        // Redirect while waiting; the late word must never surface.
        apply(0, 0, 32'h0, 0, 32'h0, 1);
        apply(1, 0, 32'h0, 0, 32'h0, 1);
        apply(1, 0, 32'h0, 1, 32'h100, 1);
        check("drop_req", {31'h0, imem_req}, 32'h1);
        for (int i = 0; i < 2; i++) begin
            apply(1, 0, 32'h0, 0, 32'h0, 1);
            check("drop_hold_req", {31'h0, imem_req}, 32'h1);
            check("drop_hold_valid", {31'h0, instr_valid}, 32'h0);
        end
        apply(1, 1, 32'hDEAD_BEEF, 0, 32'h0, 1);
        check("drop_ack_req", {31'h0, imem_req}, 32'h0);
        check("drop_ack_valid", {31'h0, instr_valid}, 32'h0);
        check("drop_ack_instr", instr, NOP);
        apply(1, 0, 32'h0, 0, 32'h0, 1);
        check("drop_next_addr", imem_addr, 32'h100);
        check("drop_next_req", {31'h0, imem_req}, 32'h1);

        // Redirect coinciding with ack and ready while an entry is buffered.
        apply(0, 0, 32'h0, 0, 32'h0, 0);
        apply(1, 0, 32'h0, 0, 32'h0, 0);
        apply(1, 1, 32'hB000_0000, 0, 32'h0, 0);
        apply(1, 0, 32'h0, 0, 32'h0, 0);
        apply(1, 1, 32'hB000_0001, 1, 32'h300, 1);
        check("flush_valid", {31'h0, instr_valid}, 32'h0);
        check("flush_instr", instr, NOP);
        check("flush_req", {31'h0, imem_req}, 32'h0);
        apply(1, 0, 32'h0, 0, 32'h0, 0);
        check("flush_next_addr", imem_addr, 32'h300);

        // Full buffer flushed by a redirect to a misaligned target.
        apply(1, 1, 32'hC000_0000, 0, 32'h0, 0);
        apply(1, 0, 32'h0, 0, 32'h0, 0);
        apply(1, 1, 32'hC000_0001, 0, 32'h0, 0);
        check("full_req", {31'h0, imem_req}, 32'h0);
        check("full_head", instr, 32'hC000_0000);
        apply(1, 0, 32'h0, 1, 32'h203, 1);
        check("full_flush_valid", {31'h0, instr_valid}, 32'h0);
        check("full_flush_pc", instr_pc, 32'h0);
        apply(1, 0, 32'h0, 0, 32'h0, 1);
        check("align_addr", imem_addr, 32'h200);

        // PC wrap past the top of the address space.
        apply(1, 1, 32'hD000_0000, 0, 32'h0, 1);
        apply(1, 0, 32'h0, 1, 32'hFFFF_FFFC, 1);
        apply(1, 0, 32'h0, 0, 32'h0, 1);
        check("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
        apply(1, 1, 32'hE000_0000, 0, 32'h0, 1);
        check("wrap_head_pc", instr_pc, 32'hFFFF_FFFC);
        apply(1, 0, 32'h0, 0, 32'h0, 1);
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_req", {31'h0, imem_req}, 32'h1);

        // Reset while a request is outstanding; the stale ack is ignored.
        apply(0, 0, 32'h0, 0, 32'h0, 1);
        check("rst_mid_req", {31'h0, imem_req}, 32'h0);
        check("rst_mid_addr", imem_addr, 32'h0);
        apply(1, 1, 32'hBAD0_BAD0, 0, 32'h0, 1);
        check("stale_valid", {31'h0, instr_valid}, 32'h0);
        check("stale_addr", imem_addr, RESET_PC);
        apply(1, 0, 32'h0, 0, 32'h0, 1);
        check("stale_valid2", {31'h0, instr_valid}, 32'h0);
        apply(1, 1, 32'hF000_0000, 0, 32'h0, 0);
        check("post_rst_instr", instr, 32'hF000_0000);
        check("post_rst_pc", instr_pc, RESET_PC);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            logic a;
            a = m_out ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 15) == 0);
            apply(1'($urandom_range(0, 299) != 0), a, $urandom(),
                  1'($urandom_range(0, 15) == 0), $urandom(),
                  1'($urandom_range(0, 3) != 0));
            compare_model();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
